// File: rtl/mask_frame_sequencer.sv
// Frame sequencer for mask_generation_top: walks a small table of mask
// configurations, resetting, loading and row-gating the generator per entry.
module mask_frame_sequencer #(
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int SETUP_CYC = 2,
  parameter int H_W       = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [1:0]     cfg_mask_type,
  input  logic [4:0]     cfg_pattern_w,
  input  logic [4:0]     cfg_pattern_h,
  input  logic [63:0]    cfg_full_pattern,
  input  logic           cfg_right_sliding,
  input  logic [7:0]     cfg_frames,
  input  logic [AW:0]    prog_len,
  input  logic           loop_en,
  input  logic           start,
  input  logic           stop,
  input  logic [H_W-1:0] image_sensor_h,
  input  logic           row_ready,
  input  logic           gen_rp_valid,
  output logic           gen_rst,
  output logic           gen_clk_en,
  output logic           gen_start_pattern,
  output logic [1:0]     gen_mask_type,
  output logic [4:0]     gen_pattern_w,
  output logic [4:0]     gen_pattern_h,
  output logic [63:0]    gen_full_pattern,
  output logic           gen_right_sliding,
  output logic           busy,
  output logic           frame_start,
  output logic           frame_done,
  output logic           prog_done,
  output logic [AW-1:0]  cur_entry,
  output logic [H_W-1:0] row_cnt,
  output logic [7:0]     frame_cnt,
  output logic           err_cfg
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRST, S_LOAD, S_SETUP, S_RUN, S_NEXT, S_DONE, S_ABORT
  } state_t;

  typedef struct packed {
    logic [1:0]  mask_type;
    logic [4:0]  pattern_w;
    logic [4:0]  pattern_h;
    logic [63:0] full_pattern;
    logic        right_sliding;
    logic [7:0]  frames;
  } entry_t;

  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  entry_t         table_q [DEPTH];
  state_t         state_q, state_d;
  logic [SW-1:0]  setup_cnt_q;
  logic [7:0]     frames_q;

  entry_t         cur_cfg;
  logic           entry_bad;
  logic [H_W-1:0] last_row;
  logic           row_counted;
  logic           row_last;
  logic           frames_last;
  logic           setup_last;
  logic [AW:0]    next_idx;
  logic           start_ok;

  // NOTE: the table has no reset; its contents are undefined until the
  // processor writes them, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE)
      table_q[cfg_addr] <= '{mask_type:     cfg_mask_type,
                             pattern_w:     cfg_pattern_w,
                             pattern_h:     cfg_pattern_h,
                             full_pattern:  cfg_full_pattern,
                             right_sliding: cfg_right_sliding,
                             frames:        cfg_frames};
  end

  assign cur_cfg     = table_q[cur_entry];
  assign entry_bad   = (cur_cfg.mask_type == 2'b11) || (cur_cfg.frames == 8'd0);
  // A zero-height frame behaves as a one-row frame.
  assign last_row    = (image_sensor_h == '0) ? '0 : image_sensor_h - H_W'(1);
  assign row_counted = (state_q == S_RUN) && !stop && row_ready && gen_rp_valid;
  assign row_last    = row_counted && (row_cnt == last_row);
  assign frames_last = (frame_cnt == frames_q - 8'd1);
  assign setup_last  = (setup_cnt_q == SW'(SETUP_CYC - 1));
  assign next_idx    = {1'b0, cur_entry} + (AW+1)'(1);
  assign start_ok    = start && !stop;

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = (prog_len == '0) ? S_DONE : S_GRST;
      S_GRST:  state_d = entry_bad ? S_NEXT : S_LOAD;
      S_LOAD:  state_d = S_SETUP;
      S_SETUP: if (setup_last) state_d = S_RUN;
      S_RUN:   if (row_last && frames_last) state_d = S_NEXT;
      S_NEXT:  state_d = (next_idx < prog_len || loop_en) ? S_GRST : S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE && state_q != S_ABORT)
      state_d = S_ABORT;
  end

  always_comb begin
    gen_rst           = (state_q == S_GRST) || (state_q == S_ABORT);
    gen_start_pattern = (state_q == S_LOAD);
    gen_clk_en        = (state_q == S_LOAD) || (state_q == S_SETUP) ||
                        ((state_q == S_RUN) && row_ready);
    busy              = (state_q != S_IDLE);
    prog_done         = (state_q == S_DONE);
    frame_start       = row_counted && (row_cnt == '0);
    frame_done        = row_last;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      cur_entry         <= '0;
      row_cnt           <= '0;
      frame_cnt         <= '0;
      setup_cnt_q       <= '0;
      frames_q          <= '0;
      err_cfg           <= 1'b0;
      gen_mask_type     <= '0;
      gen_pattern_w     <= '0;
      gen_pattern_h     <= '0;
      gen_full_pattern  <= '0;
      gen_right_sliding <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ABORT) begin
        cur_entry   <= '0;
        row_cnt     <= '0;
        frame_cnt   <= '0;
        setup_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: if (start_ok) begin
            err_cfg   <= (prog_len == '0);
            cur_entry <= '0;
            row_cnt   <= '0;
            frame_cnt <= '0;
          end
          S_GRST: begin
            gen_mask_type     <= cur_cfg.mask_type;
            gen_pattern_w     <= cur_cfg.pattern_w;
            gen_pattern_h     <= cur_cfg.pattern_h;
            gen_full_pattern  <= cur_cfg.full_pattern;
            gen_right_sliding <= cur_cfg.right_sliding;
            frames_q          <= cur_cfg.frames;
            setup_cnt_q       <= '0;
            if (entry_bad) err_cfg <= 1'b1;
          end
          S_SETUP: setup_cnt_q <= setup_cnt_q + SW'(1);
          // Frames roll over without reloading so generator state carries on.
          S_RUN: if (row_counted) begin
            if (row_last) begin
              row_cnt   <= '0;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              row_cnt   <= row_cnt + H_W'(1);
            end
          end
          S_NEXT: begin
            frame_cnt <= '0;
            row_cnt   <= '0;
            if (next_idx < prog_len) cur_entry <= next_idx[AW-1:0];
            else if (loop_en)        cur_entry <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mask_frame_sequencer.sv
// Self-checking bench for mask_frame_sequencer: a procedural model walks the
// program entry by entry with randomized sensor handshakes.
module tb_mask_frame_sequencer;

  localparam int DEPTH = 8, AW = 3, SETUP_CYC = 2, H_W = 11;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0] cfg_mask_type;
  logic [4:0] cfg_pattern_w, cfg_pattern_h;
  logic [63:0] cfg_full_pattern;
  logic cfg_right_sliding;
  logic [7:0] cfg_frames;
  logic [AW:0] prog_len;
  logic loop_en, start, stop;
  logic [H_W-1:0] image_sensor_h;
  logic row_ready, gen_rp_valid;
  logic gen_rst, gen_clk_en, gen_start_pattern;
  logic [1:0] gen_mask_type;
  logic [4:0] gen_pattern_w, gen_pattern_h;
  logic [63:0] gen_full_pattern;
  logic gen_right_sliding, busy, frame_start, frame_done, prog_done;
  logic [AW-1:0] cur_entry;
  logic [H_W-1:0] row_cnt;
  logic [7:0] frame_cnt;
  logic err_cfg;

  mask_frame_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETUP_CYC(SETUP_CYC), .H_W(H_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask_type(cfg_mask_type), .cfg_pattern_w(cfg_pattern_w),
    .cfg_pattern_h(cfg_pattern_h), .cfg_full_pattern(cfg_full_pattern),
    .cfg_right_sliding(cfg_right_sliding), .cfg_frames(cfg_frames),
    .prog_len(prog_len), .loop_en(loop_en), .start(start), .stop(stop),
    .image_sensor_h(image_sensor_h), .row_ready(row_ready), .gen_rp_valid(gen_rp_valid),
    .gen_rst(gen_rst), .gen_clk_en(gen_clk_en), .gen_start_pattern(gen_start_pattern),
    .gen_mask_type(gen_mask_type), .gen_pattern_w(gen_pattern_w),
    .gen_pattern_h(gen_pattern_h), .gen_full_pattern(gen_full_pattern),
    .gen_right_sliding(gen_right_sliding), .busy(busy), .frame_start(frame_start),
    .frame_done(frame_done), .prog_done(prog_done), .cur_entry(cur_entry),
    .row_cnt(row_cnt), .frame_cnt(frame_cnt), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  w;
    logic [4:0]  h;
    logic [63:0] p;
    logic        r;
    logic [7:0]  f;
  } ent_t;

  ent_t tm [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    row_ready    = 1'($urandom_range(1));
    gen_rp_valid = 1'($urandom_range(1));
  endtask

  task automatic write_entry(input int a, input logic [1:0] t, input logic [4:0] w,
                             input logic [4:0] h, input logic [63:0] p, input logic r,
                             input logic [7:0] f);
    cfg_addr = AW'(a); cfg_mask_type = t; cfg_pattern_w = w; cfg_pattern_h = h;
    cfg_full_pattern = p; cfg_right_sliding = r; cfg_frames = f; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tm[a].t = t; tm[a].w = w; tm[a].h = h; tm[a].p = p; tm[a].r = r; tm[a].f = f;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_gen_rst"}, 64'(gen_rst), 64'd0);
    check({tag, "_clk_en"}, 64'(gen_clk_en), 64'd0);
    check({tag, "_row_cnt"}, 64'(row_cnt), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  // Walks one started program. abort_kind: 0 none, 1 stop, 2 rst, applied in
  // the RUN cycle where abort_row rows have been counted in total.
  task automatic run_program(input int ready_pct, input int valid_pct, input int abort_kind,
                             input int abort_row, input int stall_row, input int stall_len,
                             output int cycles);
    int e = 0, rows_total = 0, cyc = 0, stall_left = stall_len;
    bit exp_err = 0, done = 0, bad, rdy, vld, cnt;
    int rows, frames, hh, guard;
    cycles = 0;
    if (prog_len == 0) begin
      drive_rand(); #1;
      check("empty_prog_done", 64'(prog_done), 64'd1);
      check("empty_err", 64'(err_cfg), 64'd1);
      check("empty_no_gen_rst", 64'(gen_rst), 64'd0);
      tick();
      check("empty_idle", 64'(busy), 64'd0);
      check("empty_err_sticky", 64'(err_cfg), 64'd1);
      return;
    end
    while (!done) begin
      if (cyc > 20000) begin
        check("program_timeout", 64'd1, 64'd0);
        return;
      end
      drive_rand(); #1;
      check("grst_rst", 64'(gen_rst), 64'd1);
      check("grst_entry", 64'(cur_entry), 64'(e));
      check("grst_clk_en", 64'(gen_clk_en), 64'd0);
      check("grst_err", 64'(err_cfg), 64'(exp_err));
      bad = (tm[e].t == 2'b11) || (tm[e].f == 8'd0);
      tick(); cyc++;
      if (!bad) begin
        drive_rand(); #1;
        check("load_start", 64'(gen_start_pattern), 64'd1);
        check("load_clk_en", 64'(gen_clk_en), 64'd1);
        check("load_rst", 64'(gen_rst), 64'd0);
        check("load_type", 64'(gen_mask_type), 64'(tm[e].t));
        check("load_w", 64'(gen_pattern_w), 64'(tm[e].w));
        check("load_h", 64'(gen_pattern_h), 64'(tm[e].h));
        check("load_pattern", gen_full_pattern, tm[e].p);
        check("load_right", 64'(gen_right_sliding), 64'(tm[e].r));
        tick(); cyc++;
        for (int s = 0; s < SETUP_CYC; s++) begin
          drive_rand(); #1;
          check("setup_clk_en", 64'(gen_clk_en), 64'd1);
          check("setup_start", 64'(gen_start_pattern), 64'd0);
          check("setup_fstart", 64'(frame_start), 64'd0);
          tick(); cyc++;
        end
        rows = 0; frames = 0; guard = 0;
        hh = (image_sensor_h == 0) ? 1 : int'(image_sensor_h);
        while (frames < int'(tm[e].f)) begin
          if (++guard > 3000) begin
            check("run_timeout", 64'd1, 64'd0);
            start = 1'b0; cfg_we = 1'b0;
            return;
          end
          rdy = ($urandom_range(99) < 32'(ready_pct));
          vld = ($urandom_range(99) < 32'(valid_pct));
          if (stall_row >= 0 && rows_total == stall_row && stall_left > 0) begin
            rdy = 0; stall_left--;
          end
          row_ready = rdy; gen_rp_valid = vld;
          if (abort_kind != 0 && rows_total == abort_row) begin
            start = 1'b0; cfg_we = 1'b0;
            if (abort_kind == 1) begin
              stop = 1'b1; #1;
              check("stop_no_fdone", 64'(frame_done), 64'd0);
              check("stop_no_fstart", 64'(frame_start), 64'd0);
              tick();
              stop = 1'b0; drive_rand(); #1;
              check("abort_gen_rst", 64'(gen_rst), 64'd1);
              check("abort_clk_en", 64'(gen_clk_en), 64'd0);
              check("abort_no_pdone", 64'(prog_done), 64'd0);
              check("abort_busy", 64'(busy), 64'd1);
              tick();
              check_idle_zero("after_stop");
            end else begin
              rst = 1'b1;
              tick();
              rst = 1'b0; #1;
              check_idle_zero("after_rst");
              check("after_rst_start", 64'(gen_start_pattern), 64'd0);
              check("after_rst_entry", 64'(cur_entry), 64'd0);
              check("after_rst_err", 64'(err_cfg), 64'd0);
              check("after_rst_pattern", gen_full_pattern, 64'd0);
              check("after_rst_type", 64'(gen_mask_type), 64'd0);
              check("after_rst_pdone", 64'(prog_done), 64'd0);
            end
            cycles = cyc;
            return;
          end
          start = 1'($urandom_range(3) == 0);
          cfg_we = 1'($urandom_range(3) == 0);
          cfg_addr = AW'($urandom_range(DEPTH - 1));
          cfg_mask_type = 2'($urandom); cfg_frames = 8'($urandom);
          cfg_full_pattern = {$urandom, $urandom};
          #1;
          cnt = rdy && vld;
          check("run_clk_en", 64'(gen_clk_en), 64'(rdy));
          check("run_row_cnt", 64'(row_cnt), 64'(rows));
          check("run_frame_cnt", 64'(frame_cnt), 64'(frames));
          check("run_pattern_hold", gen_full_pattern, tm[e].p);
          check("run_fstart", 64'(frame_start), 64'(cnt && rows == 0));
          check("run_fdone", 64'(frame_done), 64'(cnt && rows == hh - 1));
          check("run_no_pdone", 64'(prog_done), 64'd0);
          if (cnt) begin
            rows_total++;
            if (rows == hh - 1) begin rows = 0; frames++; end
            else rows++;
          end
          tick(); cyc++;
        end
        start = 1'b0; cfg_we = 1'b0;
        check("next_fcnt", 64'(frame_cnt), 64'(tm[e].f));
      end else begin
        exp_err = 1;
      end
      drive_rand(); #1;
      check("next_clk_en", 64'(gen_clk_en), 64'd0);
      check("next_start", 64'(gen_start_pattern), 64'd0);
      check("next_busy", 64'(busy), 64'd1);
      check("next_err", 64'(err_cfg), 64'(exp_err));
      check("next_no_pdone", 64'(prog_done), 64'd0);
      tick(); cyc++;
      if (e + 1 < int'(prog_len)) e++;
      else if (loop_en) e = 0;
      else done = 1;
    end
    drive_rand(); #1;
    check("done_pdone", 64'(prog_done), 64'd1);
    check("done_busy", 64'(busy), 64'd1);
    check("done_err", 64'(err_cfg), 64'(exp_err));
    tick(); cyc++;
    check("done_idle", 64'(busy), 64'd0);
    check("done_pulse_once", 64'(prog_done), 64'd0);
    cycles = cyc;
  endtask

  initial begin
    int c1, c2, c;
    rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_mask_type = '0; cfg_pattern_w = '0;
    cfg_pattern_h = '0; cfg_full_pattern = '0; cfg_right_sliding = 0; cfg_frames = '0;
    prog_len = '0; loop_en = 0; start = 0; stop = 0; image_sensor_h = '0;
    row_ready = 0; gen_rp_valid = 0;
    tick(); tick();
    rst = 1'b0; #1;
    check_idle_zero("reset");
    check("reset_err", 64'(err_cfg), 64'd0);
    check("reset_pdone", 64'(prog_done), 64'd0);
    check("reset_entry", 64'(cur_entry), 64'd0);

    // Single repeated entry, two frames of four rows.
    write_entry(0, 2'b00, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 1'b0, 8'd2);
    prog_len = 1; loop_en = 0; image_sensor_h = 4;
    start_pulse();
    run_program(100, 100, 0, 0, -1, 0, c1);
    check("t1_cycles", 64'(c1), 64'(4 + SETUP_CYC + 8));

    // Same program with a five-cycle back-pressure after row 2.
    start_pulse();
    run_program(100, 100, 0, 0, 2, 5, c2);
    check("t2_stall_delay", 64'(c2), 64'(c1 + 5));

    // Looping two-entry program, stopped mid-run in its fifth entry.
    write_entry(0, 2'b10, 5'd3, 5'd2, 64'h0123456789ABCDEF, 1'b0, 8'd1);
    write_entry(1, 2'b01, 5'd5, 5'd3, 64'hDEADBEEF00C0FFEE, 1'b1, 8'd1);
    prog_len = 2; loop_en = 1; image_sensor_h = 3;
    start_pulse();
    run_program(80, 80, 1, 13, -1, 0, c);

    // Illegal entry is skipped and flagged; the next entry still runs.
    write_entry(0, 2'b11, 5'd4, 5'd4, 64'h5555AAAA5555AAAA, 1'b0, 8'd1);
    write_entry(1, 2'b00, 5'd2, 5'd2, 64'h00000000FFFF0000, 1'b0, 8'd2);
    loop_en = 0; image_sensor_h = 2;
    start_pulse();
    run_program(90, 90, 0, 0, -1, 0, c);

    // Empty program, then start and stop together in idle.
    prog_len = 0;
    start_pulse();
    run_program(100, 100, 0, 0, -1, 0, c);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; #1;
    check("start_stop_idle", 64'(busy), 64'd0);

    // Reset mid-frame, then reload and run to completion.
    write_entry(0, 2'b00, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 1'b0, 8'd2);
    prog_len = 1; image_sensor_h = 4;
    start_pulse();
    run_program(100, 100, 2, 2, -1, 0, c);
    write_entry(0, 2'b01, 5'd6, 5'd3, 64'h1234_5678_9ABC_DEF0, 1'b1, 8'd1);
    start_pulse();
    run_program(100, 100, 0, 0, -1, 0, c);

    // Randomized programs, including zero-height frames and illegal entries.
    for (int it = 0; it < 12; it++) begin
      int pl;
      pl = 1 + $urandom_range(2);
      for (int a = 0; a < pl; a++)
        write_entry(a, ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2)),
                    5'($urandom), 5'($urandom), {$urandom, $urandom}, 1'($urandom),
                    ($urandom_range(9) == 0) ? 8'd0 : 8'(1 + $urandom_range(2)));
      prog_len = (AW+1)'(pl);
      loop_en = 0;
      image_sensor_h = H_W'($urandom_range(4));
      start_pulse();
      run_program(60 + $urandom_range(40), 60 + $urandom_range(40), 0, 0, -1, 0, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_frame_sequencer.md
Name: mask_frame_sequencer

Overview:
- Programmable controller that sequences mask_generation_top across frames.
- Holds a small table of mask configurations (repeated, sliding, random) written by the micro-processor.
- For each entry, resets the generator, loads the pattern, then gates the generator clock enable row by row against the sensor's readiness.
- Counts rows and frames, advances through the table, and optionally loops.

Parameters:
DEPTH, 8, number of program table entries (power of 2)
AW, 3, table address width, $clog2(DEPTH)
SETUP_CYC, 2, cycles of gen_clk_en after gen_start_pattern before rows are counted (sliding mode needs 2)
H_W, 11, width of image_sensor_h and row counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_mask_type  in  2  00 repeated, 01 sliding, 10 random, 11 illegal
cfg_pattern_w  in  5  pattern width
cfg_pattern_h  in  5  pattern height
cfg_full_pattern  in  64  pattern bits
cfg_right_sliding  in  1  sliding direction
cfg_frames  in  8  frames to run for this entry (0 illegal)
prog_len  in  AW+1  number of valid entries (0..DEPTH)
loop_en  in  1  restart at entry 0 after the last entry
start  in  1  start program (pulse)
stop  in  1  abort program (pulse)
image_sensor_h  in  H_W  rows per frame
row_ready  in  1  sensor can accept a row this cycle
gen_rp_valid  in  1  generator row valid
gen_rst  out  1  active-high reset to generator
gen_clk_en  out  1  generator clock enable
gen_start_pattern  out  1  generator load strobe
gen_mask_type  out  2  registered config to generator
gen_pattern_w  out  5  registered config to generator
gen_pattern_h  out  5  registered config to generator
gen_full_pattern  out  64  registered config to generator
gen_right_sliding  out  1  registered config to generator
busy  out  1  state is not IDLE
frame_start  out  1  pulse on the first valid row of each frame
frame_done  out  1  pulse on the last valid row of each frame
prog_done  out  1  pulse when the program finishes
cur_entry  out  AW  active entry index
row_cnt  out  H_W  rows completed in the current frame
frame_cnt  out  8  frames completed in the current entry
err_cfg  out  1  sticky; set on an illegal entry or a start with prog_len=0; cleared on an accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; table contents undefined.
- Table writes:
  - Accepted only in IDLE.
  - cfg_we while busy is ignored.
- FSM states: IDLE, GRST, LOAD, SETUP, RUN, NEXT, DONE.
- IDLE: start at edge k:
  - Clears err_cfg.
  - cur_entry=0.
  - Goes to GRST, or to DONE with err_cfg=1 if prog_len=0.
- GRST (cycle k+1):
  - gen_rst=1 for one cycle.
  - gen_* config registered from table[cur_entry].
  - Goes to NEXT, setting err_cfg, if mask_type=11 or frames=0.
  - Otherwise goes to LOAD.
- LOAD (k+2): gen_start_pattern=1 and gen_clk_en=1 for one cycle.
- SETUP (k+3 .. k+2+SETUP_CYC):
  - gen_clk_en=1.
  - gen_rp_valid is ignored.
- RUN (from k+3+SETUP_CYC):
  - gen_clk_en = row_ready.
  - A row is counted only when gen_clk_en & gen_rp_valid.
- Row counting:
  - frame_start pulses when a row is counted with row_cnt=0.
  - When the counted row has row_cnt = image_sensor_h-1: frame_done pulses, row_cnt goes to 0, frame_cnt increments.
  - If frame_cnt = frames-1 at that point, go to NEXT.
  - Otherwise stay in RUN without reloading, so generator state (random LFSR, slide position) continues across frames.
- image_sensor_h=0 in RUN: treated as 1, so every counted row ends a frame.
- NEXT (1 cycle):
  - gen_clk_en=0; frame_cnt=0.
  - If cur_entry+1 < prog_len: cur_entry++, go to GRST.
  - Else if loop_en: cur_entry=0, go to GRST.
  - Else go to DONE.
- DONE (1 cycle): prog_done=1, then IDLE.
- stop in any busy state:
  - Next cycle enters GRST-abort: gen_rst=1, gen_clk_en=0, then IDLE.
  - Counters cleared; no frame_done or prog_done.
- stop and start in the same cycle: stop wins (no effect in IDLE).
- start while busy: ignored.
- Mid-frame reset: rst overrides everything, and the next cycle shows reset values.
- gen_* config is held stable from GRST of an entry until the next GRST.
- Counter widths:
  - row_cnt wraps only via the frame rule.
  - frame_cnt max 255.

Test Plan:
1. prog_len=1; entry0 = repeated, w=4, h=4, pattern 64'hF0ABC9820EAA17CD, frames=2; image_sensor_h=4; row_ready=1; gen_rp_valid tied 1 in RUN -> gen_start_pattern exactly once at k+2; 8 rows counted; frame_done after rows 4 and 8; prog_done one cycle after NEXT; busy low afterwards.
2. Same setup, row_ready=0 for 5 cycles after row 2 -> gen_clk_en=0 for those 5 cycles; row_cnt holds at 2; totals unchanged; completion delayed exactly 5 cycles.
3. prog_len=2; entry0 random, frames=1; entry1 sliding, right=1, frames=1; loop_en=1; image_sensor_h=3 -> gen_rst/LOAD sequence before each entry; cur_entry goes 0,1,0,1...; no prog_done; stop -> IDLE with gen_rst pulse.
4. entry0 mask_type=11, entry1 valid repeated, prog_len=2 -> entry0 skipped with no gen_start_pattern; err_cfg=1; entry1 runs; prog_done asserted.
5. cfg_we to entry0 while RUN -> table unchanged; next run uses the old values; start while busy has no effect.
6. Assert rst mid-RUN (row_cnt=2) -> next cycle all outputs 0 and IDLE; a new start after reloading the table completes normally.
